// File: rtl/motor_pkg.sv
// Shared encodings and helpers for the four-channel H-bridge PWM driver.
package motor_pkg;

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_RUN,
    ST_BRAKE
  } ch_state_t;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: IDLE/DEAD/RUN/BRAKE FSM, dead-time counter, duty ramp, registered pins.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 2500,
  parameter int unsigned DUTY_MAX    = 2000,
  parameter int unsigned RAMP_STEP   = 50,
  parameter int unsigned DEAD_CYCLES = 5000,
  parameter int unsigned PW          = cnt_w(PWM_PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cmd,
  input  logic [PW-1:0] pwm_cnt,
  input  logic          ramp_tick,
  output logic          in_a,
  output logic          in_b,
  output logic          en_pwm,
  output logic          at_speed
);

  localparam int unsigned DW = cnt_w(PWM_PERIOD + 1);
  localparam int unsigned KW = cnt_w(DEAD_CYCLES);
  localparam logic [DW-1:0] DMAX      = DW'(DUTY_MAX);
  localparam logic [KW-1:0] DEAD_LAST = KW'(DEAD_CYCLES - 1);

  ch_state_t     state, state_n;
  logic [1:0]    dir, dir_n;
  logic [DW-1:0] duty, duty_n, duty_ramped;
  logic [DW:0]   duty_sum;
  logic [KW-1:0] dead_cnt, dead_n;

  // One extra bit so the ramp sum saturates instead of wrapping.
  assign duty_sum    = {1'b0, duty} + (DW + 1)'(RAMP_STEP);
  assign duty_ramped = (duty_sum > (DW + 1)'(DUTY_MAX)) ? DMAX : duty_sum[DW-1:0];

  always_comb begin
    state_n = state;
    dir_n   = dir;
    duty_n  = duty;
    dead_n  = dead_cnt;
    unique case (state)
      ST_IDLE: begin
        duty_n = '0;
        if (cmd != CMD_COAST) begin
          state_n = ST_DEAD;
          dir_n   = cmd;
          dead_n  = '0;
        end
      end
      ST_DEAD: begin
        duty_n = '0;
        if (cmd == CMD_COAST) begin
          state_n = ST_IDLE;
        end else if (cmd != dir) begin
          dir_n  = cmd;
          dead_n = '0;
        end else if (dead_cnt == DEAD_LAST) begin
          state_n = (dir == CMD_BRAKE) ? ST_BRAKE : ST_RUN;
          dead_n  = '0;
        end else begin
          dead_n = dead_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (ramp_tick) duty_n = duty_ramped;
        if (cmd == CMD_COAST) begin
          state_n = ST_IDLE;
          duty_n  = '0;
        end else if (cmd != dir) begin
          state_n = ST_DEAD;
          dir_n   = cmd;
          dead_n  = '0;
          duty_n  = '0;
        end
      end
      ST_BRAKE: begin
        if (cmd == CMD_COAST) begin
          state_n = ST_IDLE;
        end else if (cmd != CMD_BRAKE) begin
          state_n = ST_DEAD;
          dir_n   = cmd;
          dead_n  = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir      <= CMD_COAST;
      duty     <= '0;
      dead_cnt <= '0;
      in_a     <= 1'b0;
      in_b     <= 1'b0;
      en_pwm   <= 1'b0;
      at_speed <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      duty     <= duty_n;
      dead_cnt <= dead_n;
      in_a     <= (state_n == ST_BRAKE) || (state_n == ST_RUN && dir_n == CMD_FWD);
      in_b     <= (state_n == ST_BRAKE) || (state_n == ST_RUN && dir_n == CMD_REV);
      en_pwm   <= (state_n == ST_BRAKE) || (state_n == ST_RUN && DW'(pwm_cnt) < duty_n);
      at_speed <= (state_n == ST_RUN) && (duty_n == DMAX);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Four-channel H-bridge driver: registered command, shared PWM counter and ramp prescaler.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 2500,
  parameter int unsigned DUTY_MAX    = 2000,
  parameter int unsigned RAMP_STEP   = 50,
  parameter int unsigned RAMP_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sel_in,
  output logic [3:0] in_a,
  output logic [3:0] in_b,
  output logic [3:0] en_pwm,
  output logic [3:0] at_speed
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned PW     = cnt_w(PWM_PERIOD);
  localparam int unsigned RW     = cnt_w(RAMP_DIV);

  logic [7:0]    sel_q;
  logic [PW-1:0] pwm_cnt;
  logic [RW-1:0] div_cnt;
  logic          ramp_tick;

  assign ramp_tick = (div_cnt == RW'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      sel_q   <= sel_in;
      pwm_cnt <= (pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
      div_cnt <= ramp_tick ? '0 : div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_channel #(
      .PWM_PERIOD (PWM_PERIOD),
      .DUTY_MAX   (DUTY_MAX),
      .RAMP_STEP  (RAMP_STEP),
      .DEAD_CYCLES(DEAD_CYCLES),
      .PW         (PW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cmd      (sel_q[2*i+1:2*i]),
      .pwm_cnt  (pwm_cnt),
      .ramp_tick(ramp_tick),
      .in_a     (in_a[i]),
      .in_b     (in_b[i]),
      .en_pwm   (en_pwm[i]),
      .at_speed (at_speed[i])
    );
  end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Final drive stage: consumes the 8-bit protected motion command from the movement controller and converts it into H-bridge direction lines plus PWM enables for four motor channels. Each channel has a duty-cycle soft-start ramp, an enforced dead-time on direction change, and a brake mode. All outputs are registered and glitch-free, so the block connects directly to FPGA pins.

## Interface
- PWM_PERIOD, 2500: clocks per PWM period (20 kHz at 50 MHz).
- DUTY_MAX, 2000: ramp ceiling in counts; must be ≤ PWM_PERIOD.
- RAMP_STEP, 50: duty increment per ramp tick.
- RAMP_DIV, 50000: clocks per ramp tick (1 ms at 50 MHz).
- DEAD_CYCLES, 5000: clocks all-off on direction change.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sel_in  in  8  command; channel i uses bits [2i+1:2i] = {rev,fwd}: 00 coast, 01 forward, 10 reverse, 11 brake.
- in_a  out  4  H-bridge input A per channel.
- in_b  out  4  H-bridge input B per channel.
- en_pwm  out  4  bridge enable / PWM per channel.
- at_speed  out  4  channel in RUN with duty == DUTY_MAX.

## Operation
- sel_in registered once (sel_q). All decisions use sel_q.
- Shared PWM counter: 0..PWM_PERIOD-1, wraps to 0. Shared ramp prescaler: 0..RAMP_DIV-1; ramp_tick is a one-cycle pulse on wrap.
- Per-channel FSM states: IDLE, DEAD, RUN, BRAKE. Each channel also holds a latched direction (dir) and duty (width clog2(PWM_PERIOD+1)).
- IDLE: in_a=in_b=en=0, duty=0.
  - cmd 01/10 → DEAD with dir=cmd.
  - cmd 11 → DEAD with dir=brake.
- DEAD: all outputs 0, duty=0. Counts DEAD_CYCLES clocks, then → RUN (fwd/rev) or BRAKE.
  - A new non-zero cmd different from the latched dir restarts the count with the new dir.
  - cmd 00 → IDLE.
- RUN:
  - Forward: in_a=1, in_b=0. Reverse: in_a=0, in_b=1.
  - en = (pwm_cnt < duty).
  - On ramp_tick, duty = min(duty+RAMP_STEP, DUTY_MAX); the sum is computed one bit wider so it cannot wrap.
  - cmd equal to dir: stay. cmd 00 → IDLE. Any other non-zero cmd → DEAD with the new dir.
- BRAKE: in_a=in_b=en=1. cmd 00 → IDLE. cmd 01/10 → DEAD.
- at_speed = (state==RUN && duty==DUTY_MAX).
- Channels are fully independent. Simultaneous changes on several channels are each handled in the same cycle.

## Timing
- Reset: all outputs 0, all FSMs IDLE, duty 0, counters 0, sel_q 0. Reset mid-operation drops every output to 0 asynchronously.
- Latency from a sel_in change to the state/output change: 2 clocks (sel_q, then the registered FSM/outputs).
- DEAD lasts exactly DEAD_CYCLES clocks with all three outputs low. The first RUN/BRAKE output appears on the next clock.
- Ramp:
  - First duty increment occurs on the first ramp_tick after entering RUN. Duty is not aligned to the PWM period.
  - The en compare uses the current duty, so mid-period updates only ever lengthen the high time.
  - Full ramp takes ceil(DUTY_MAX/RAMP_STEP) ticks.
- Edge cases:
  - duty==0 gives en constantly 0.
  - duty==PWM_PERIOD gives en constantly 1.
- in_a and in_b are never 1 at the same time except in BRAKE. Every transition from fwd to rev, or into/out of BRAKE from a driven state, passes through DEAD.

## Structure
- Package motor_pkg holds:
  - command encodings CMD_COAST/CMD_FWD/CMD_REV/CMD_BRAKE;
  - channel state encoding;
  - a clog2-based width function.
- Top holds sel_q, the PWM counter and the ramp prescaler.
- Sub-module motor_channel (FSM, dead counter, duty, output registers) is instantiated 4× with generate. Inputs: cmd[1:0], pwm_cnt, ramp_tick.

## Test plan
Bench parameters: PWM_PERIOD=10, DUTY_MAX=8, RAMP_STEP=3, RAMP_DIV=4, DEAD_CYCLES=5.
- Reset, then sel_in=0x00 for 50 clocks → all outputs 0, at_speed=0.
- sel_in=0x01 → channel 0 outputs stay 0 for 2+5 clocks. Then in_a[0]=1, in_b[0]=0. Duty steps 3, 6, 8 on successive ramp_ticks. At duty 8, en_pwm[0] is high 8 of every 10 clocks and at_speed[0]=1.
- Channel 0 at speed, sel_in=0x02 → within 2 clocks all channel-0 outputs go 0 for 5 clocks. Then in_b[0]=1 with the ramp restarting from 0. in_a[0] and in_b[0] are never high together.
- sel_in=0xC0 → channel 3 passes 5 clocks of DEAD, then in_a=in_b=en_pwm=1. Then sel_in=0x00 → channel 3 goes all 0 after 2 clocks.
- In DEAD on channel 1 (cmd 01), switch to cmd 10 at dead count 3 → count restarts. Channel 1 enters RUN reverse exactly 5 clocks after the change is registered.
- All channels running, assert rst mid PWM period → all outputs 0 immediately. After release with sel_in held, each channel repeats DEAD then ramps from 0.
